// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions used by the branch hazard controller.
//   REG_ADDR_W : architectural register index width
//   X0         : index of the hard-wired zero register
//   hz_state_e : hazard FSM state (RUN = evaluating, HOLD = second load-use stall)
package rv32_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Pipeline-side bundle of the ID-stage branch hazard controller.
//   Inputs to the controller : IF/ID branch operands, ID/EX and EX/MEM producer
//                              info, comparator result.
//   Outputs of the controller: PC/IF-ID write enables, ID/EX bubble, IF/ID flush.
//   master : pipeline side (drives operands, receives control)
//   slave  : hazard controller side
interface branch_hazard_unit_if;
  import rv32_pkg::*;

  logic                  IFID_Is_Branch;
  logic [REG_ADDR_W-1:0] IFID_Reg_RS1;
  logic [REG_ADDR_W-1:0] IFID_Reg_RS2;
  logic                  IFID_Uses_RS2;
  logic [REG_ADDR_W-1:0] IDEX_Reg_RD;
  logic                  IDEX_RegWrite;
  logic                  IDEX_MemRead;
  logic [REG_ADDR_W-1:0] EXMEM_Reg_RD;
  logic                  EXMEM_RegWrite;
  logic                  EXMEM_MemRead;
  logic                  Branch_Taken;
  logic                  PC_Write;
  logic                  IFID_Write;
  logic                  IDEX_Bubble;
  logic                  IFID_Flush;

  modport master (
    output IFID_Is_Branch, IFID_Reg_RS1, IFID_Reg_RS2, IFID_Uses_RS2,
           IDEX_Reg_RD, IDEX_RegWrite, IDEX_MemRead,
           EXMEM_Reg_RD, EXMEM_RegWrite, EXMEM_MemRead, Branch_Taken,
    input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush
  );

  modport slave (
    input  IFID_Is_Branch, IFID_Reg_RS1, IFID_Reg_RS2, IFID_Uses_RS2,
           IDEX_Reg_RD, IDEX_RegWrite, IDEX_MemRead,
           EXMEM_Reg_RD, EXMEM_RegWrite, EXMEM_MemRead, Branch_Taken,
    output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush
  );

endinterface

// File: rtl/branch_hazard_unit_dep.sv
// Register dependency detector: flags when a producer writing rd_i feeds one of
// the branch source operands. x0 never creates a dependency; rs2 only counts
// when the branch really reads it.
//   rd_i, wr_i        : producer destination and write-back enable
//   rs1_i, rs2_i      : branch source registers
//   uses_rs2_i        : rs2 is a real operand
//   dep_o             : dependency present
module branch_dep_check
  import rv32_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  wr_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  uses_rs2_i,
  output logic                  dep_o
);

  // Dependency compare against both branch operands
  always_comb begin
    dep_o = 1'b0;
    if (wr_i && (rd_i != X0)) begin
      dep_o = (rd_i == rs1_i) || (uses_rs2_i && (rd_i == rs2_i));
    end else begin
      dep_o = 1'b0;
    end
  end

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage branch hazard controller with early branch resolution.
// Stalls PC and IF/ID while a branch operand cannot yet be forwarded, flushes
// IF/ID on a taken branch, and keeps saturating stall/flush counters.
//   clk, rst_n     : clock, asynchronous active-low reset
//   hz             : pipeline bundle (slave side)
//   Clear_Counters : synchronous clear of both counters (beats increments)
//   Stall_Cnt      : saturating count of stall cycles
//   Flush_Cnt      : saturating count of taken-branch flushes
module branch_hazard_unit
  import rv32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_hazard_unit_if.slave  hz,
  input  logic                 Clear_Counters,
  output logic [CNT_W-1:0]     Stall_Cnt,
  output logic [CNT_W-1:0]     Flush_Cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_e        state_q;
  hz_state_e        state_d;
  logic             ex_dep_s;
  logic             mem_dep_s;
  logic             h2_s;
  logic             h1_s;
  logic             stall_s;
  logic             flush_s;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  branch_dep_check u_dep_ex (
    .rd_i       (hz.IDEX_Reg_RD),
    .wr_i       (hz.IDEX_RegWrite),
    .rs1_i      (hz.IFID_Reg_RS1),
    .rs2_i      (hz.IFID_Reg_RS2),
    .uses_rs2_i (hz.IFID_Uses_RS2),
    .dep_o      (ex_dep_s)
  );

  branch_dep_check u_dep_mem (
    .rd_i       (hz.EXMEM_Reg_RD),
    .wr_i       (hz.EXMEM_RegWrite),
    .rs1_i      (hz.IFID_Reg_RS1),
    .rs2_i      (hz.IFID_Reg_RS2),
    .uses_rs2_i (hz.IFID_Uses_RS2),
    .dep_o      (mem_dep_s)
  );

  // Hazard classification; a load in EX (two cycles) takes priority over one-cycle cases
  always_comb begin
    h2_s = 1'b0;
    h1_s = 1'b0;
    if (hz.IFID_Is_Branch) begin
      h2_s = ex_dep_s && hz.IDEX_MemRead;
      h1_s = !h2_s && ((ex_dep_s && !hz.IDEX_MemRead) ||
                       (mem_dep_s && hz.EXMEM_MemRead));
    end else begin
      h2_s = 1'b0;
      h1_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HOLD covers the second load-use cycle, after which the
  // load has reached MEM/WB and write-through makes it visible
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (h2_s) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
      end
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs (Mealy); a stall masks a taken result since operands are stale
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      RUN:     stall_s = h1_s || h2_s;
      HOLD:    stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
    flush_s        = hz.IFID_Is_Branch && hz.Branch_Taken && !stall_s;
    hz.PC_Write    = !stall_s;
    hz.IFID_Write  = !stall_s;
    hz.IDEX_Bubble = stall_s;
    hz.IFID_Flush  = flush_s;
  end

  // Saturating performance counters; clear overrides increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (Clear_Counters) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (flush_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench for branch_hazard_unit: directed scenarios followed by
// randomized traffic, all compared against a cycles-remaining reference model.
module tb_branch_hazard_unit;

  localparam int CW      = 2;
  localparam int CNT_TOP = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  logic clear_counters;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int total;
  int bad;

  // Reference model state: stall cycles still owed to an earlier load-use branch
  int owed;
  int m_stall_cnt;
  int m_flush_cnt;

  branch_hazard_unit_if bus ();

  branch_hazard_unit #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz             (bus),
    .Clear_Counters (clear_counters),
    .Stall_Cnt      (stall_cnt),
    .Flush_Cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Does a producer writing rd feed an operand the branch actually reads?
  function automatic bit feeds(input logic [4:0] rd, input logic wr);
    if (!wr || rd == 5'd0) return 1'b0;
    return (rd == bus.IFID_Reg_RS1) || (bus.IFID_Uses_RS2 && rd == bus.IFID_Reg_RS2);
  endfunction

  // Stall cycles the current branch needs, counted from now
  function automatic int cycles_needed();
    int n;
    n = 0;
    if (!bus.IFID_Is_Branch) return 0;
    if (feeds(bus.EXMEM_Reg_RD, bus.EXMEM_RegWrite) && bus.EXMEM_MemRead) n = 1;
    if (feeds(bus.IDEX_Reg_RD, bus.IDEX_RegWrite)) n = bus.IDEX_MemRead ? 2 : (n > 1 ? n : 1);
    return n;
  endfunction

  task automatic set_idle();
    bus.IFID_Is_Branch = 1'b0;
    bus.IFID_Reg_RS1   = 5'd0;
    bus.IFID_Reg_RS2   = 5'd0;
    bus.IFID_Uses_RS2  = 1'b0;
    bus.IDEX_Reg_RD    = 5'd0;
    bus.IDEX_RegWrite  = 1'b0;
    bus.IDEX_MemRead   = 1'b0;
    bus.EXMEM_Reg_RD   = 5'd0;
    bus.EXMEM_RegWrite = 1'b0;
    bus.EXMEM_MemRead  = 1'b0;
    bus.Branch_Taken   = 1'b0;
    clear_counters     = 1'b0;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance the model
  // at the edge, then check counters. exp_* of -1 means no directed constant.
  task automatic run_cycle(input string tag, input int exp_stall, input int exp_flush);
    bit s;
    bit f;
    int need;
    #1;
    need = cycles_needed();
    s = (owed > 0) || (need > 0);
    f = bus.IFID_Is_Branch && bus.Branch_Taken && !s;
    chk({tag, "_pcw"},    bus.PC_Write,    !s);
    chk({tag, "_ifidw"},  bus.IFID_Write,  !s);
    chk({tag, "_bubble"}, bus.IDEX_Bubble, s);
    chk({tag, "_flush"},  bus.IFID_Flush,  f);
    if (exp_stall >= 0) chk({tag, "_dstall"}, bus.IDEX_Bubble, exp_stall);
    if (exp_flush >= 0) chk({tag, "_dflush"}, bus.IFID_Flush, exp_flush);
    @(posedge clk);
    if (clear_counters) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (s && m_stall_cnt < CNT_TOP) m_stall_cnt++;
      if (f && m_flush_cnt < CNT_TOP) m_flush_cnt++;
    end
    if (owed > 0) owed--;
    else if (need == 2) owed = 1;
    #1;
    chk({tag, "_scnt"}, stall_cnt, m_stall_cnt);
    chk({tag, "_fcnt"}, flush_cnt, m_flush_cnt);
  endtask

  task automatic clear_cycle();
    set_idle();
    clear_counters = 1'b1;
    run_cycle("clr", 0, 0);
    clear_counters = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    owed = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    set_idle();
    rst_n = 1'b0;
    #12;
    chk("rst_pcw", bus.PC_Write, 1'b1);
    chk("rst_bubble", bus.IDEX_Bubble, 1'b0);
    chk("rst_flush", bus.IFID_Flush, 1'b0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: load rd=5 in EX, branch reads x5 -> two stall cycles
    bus.IFID_Is_Branch = 1'b1; bus.IFID_Reg_RS1 = 5'd5; bus.IFID_Reg_RS2 = 5'd6;
    bus.IDEX_Reg_RD = 5'd5; bus.IDEX_RegWrite = 1'b1; bus.IDEX_MemRead = 1'b1;
    run_cycle("lu1", 1, 0);
    bus.IDEX_Reg_RD = 5'd0; bus.IDEX_RegWrite = 1'b0; bus.IDEX_MemRead = 1'b0;
    bus.EXMEM_Reg_RD = 5'd5; bus.EXMEM_RegWrite = 1'b1; bus.EXMEM_MemRead = 1'b1;
    run_cycle("lu2", 1, 0);
    bus.EXMEM_Reg_RD = 5'd0; bus.EXMEM_RegWrite = 1'b0; bus.EXMEM_MemRead = 1'b0;
    run_cycle("lu3", 0, 0);
    chk("lu_scnt2", stall_cnt, 2);
    clear_cycle();

    // ALU-use on rs2: one stall with rs2 used, none when unused
    set_idle();
    bus.IFID_Is_Branch = 1'b1; bus.IFID_Reg_RS1 = 5'd1; bus.IFID_Reg_RS2 = 5'd7;
    bus.IFID_Uses_RS2 = 1'b1; bus.IDEX_Reg_RD = 5'd7; bus.IDEX_RegWrite = 1'b1;
    run_cycle("alu1", 1, 0);
    bus.IDEX_RegWrite = 1'b0;
    run_cycle("alu2", 0, 0);
    bus.IDEX_RegWrite = 1'b1; bus.IFID_Uses_RS2 = 1'b0;
    run_cycle("alu_nors2", 0, 0);

    // x0 producer never stalls
    bus.IFID_Reg_RS1 = 5'd0; bus.IDEX_Reg_RD = 5'd0;
    run_cycle("x0", 0, 0);

    // Load in MEM, branch reads x9 -> one stall
    set_idle();
    bus.IFID_Is_Branch = 1'b1; bus.IFID_Reg_RS1 = 5'd9;
    bus.EXMEM_Reg_RD = 5'd9; bus.EXMEM_RegWrite = 1'b1; bus.EXMEM_MemRead = 1'b1;
    run_cycle("memld1", 1, 0);
    bus.EXMEM_RegWrite = 1'b0; bus.EXMEM_MemRead = 1'b0;
    run_cycle("memld2", 0, 0);
    clear_cycle();

    // Taken branch without hazard flushes once
    set_idle();
    bus.IFID_Is_Branch = 1'b1; bus.IFID_Reg_RS1 = 5'd3; bus.Branch_Taken = 1'b1;
    run_cycle("tk", 0, 1);
    chk("tk_fcnt1", flush_cnt, 1);
    // Taken during an H2 stall: flush waits for the stall to end
    bus.IDEX_Reg_RD = 5'd3; bus.IDEX_RegWrite = 1'b1; bus.IDEX_MemRead = 1'b1;
    run_cycle("tkh1", 1, 0);
    bus.IDEX_RegWrite = 1'b0; bus.IDEX_MemRead = 1'b0;
    run_cycle("tkh2", 1, 0);
    run_cycle("tkh3", 0, 1);
    chk("tkh_fcnt2", flush_cnt, 2);
    clear_cycle();

    // Saturation: five stall cycles hold Stall_Cnt at 3
    set_idle();
    bus.IFID_Is_Branch = 1'b1; bus.IFID_Reg_RS1 = 5'd9;
    bus.EXMEM_Reg_RD = 5'd9; bus.EXMEM_RegWrite = 1'b1; bus.EXMEM_MemRead = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle("sat", 1, 0);
    chk("sat_scnt3", stall_cnt, 3);
    // Clear in a stall cycle wins over the increment
    clear_counters = 1'b1;
    run_cycle("clrst", 1, 0);
    clear_counters = 1'b0;
    chk("clrst_scnt0", stall_cnt, 0);

    // Reset asserted during the second load-use cycle
    set_idle();
    bus.IFID_Is_Branch = 1'b1; bus.IFID_Reg_RS1 = 5'd4;
    bus.IDEX_Reg_RD = 5'd4; bus.IDEX_RegWrite = 1'b1; bus.IDEX_MemRead = 1'b1;
    run_cycle("rh1", 1, 0);
    set_idle();
    #2;
    chk("rh_pre_bubble", bus.IDEX_Bubble, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rh_pcw", bus.PC_Write, 1'b1);
    chk("rh_bubble", bus.IDEX_Bubble, 1'b0);
    chk("rh_scnt", stall_cnt, 0);
    chk("rh_fcnt", flush_cnt, 0);
    owed = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with small register indices to force collisions
    for (int i = 0; i < 600; i++) begin
      bus.IFID_Is_Branch = ($urandom_range(0, 9) < 7);
      bus.IFID_Reg_RS1   = 5'($urandom_range(0, 3));
      bus.IFID_Reg_RS2   = 5'($urandom_range(0, 3));
      bus.IFID_Uses_RS2  = 1'($urandom_range(0, 1));
      bus.IDEX_Reg_RD    = 5'($urandom_range(0, 3));
      bus.IDEX_RegWrite  = 1'($urandom_range(0, 1));
      bus.IDEX_MemRead   = 1'($urandom_range(0, 1));
      bus.EXMEM_Reg_RD   = 5'($urandom_range(0, 3));
      bus.EXMEM_RegWrite = 1'($urandom_range(0, 1));
      bus.EXMEM_MemRead  = 1'($urandom_range(0, 1));
      bus.Branch_Taken   = 1'($urandom_range(0, 1));
      clear_counters     = ($urandom_range(0, 15) == 0);
      run_cycle("rnd", -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

ID-stage hazard controller for the RV32 five-stage pipeline with early branch resolution. It sits directly upstream of the ID-stage branch operand forwarding muxes and the branch comparator. It stalls PC and IF/ID when a branch in ID depends on a result that cannot be forwarded yet, and it flushes IF/ID when the branch resolves taken. It also keeps saturating counters of branch stall cycles and taken-branch flushes.

## Interface
- CNT_W, 16, width of each saturating performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- IFID_Is_Branch  in  1  instruction in ID is a conditional branch
- IFID_Reg_RS1 / IFID_Reg_RS2  in  5  branch source registers
- IFID_Uses_RS2  in  1  RS2 is a real operand
- IDEX_Reg_RD  in  5  destination register of the instruction in EX
- IDEX_RegWrite / IDEX_MemRead  in  1  write-back and load flags of the EX instruction
- EXMEM_Reg_RD  in  5  destination register of the instruction in MEM
- EXMEM_RegWrite / EXMEM_MemRead  in  1  write-back and load flags of the MEM instruction
- Branch_Taken  in  1  comparator result, valid only when operands are current
- Clear_Counters  in  1  synchronous counter clear
- PC_Write  out  1  PC update enable
- IFID_Write  out  1  IF/ID update enable
- IDEX_Bubble  out  1  insert a NOP into ID/EX
- IFID_Flush  out  1  zero IF/ID at the next edge
- Stall_Cnt  out  CNT_W  saturating count of branch stall cycles
- Flush_Cnt  out  CNT_W  saturating count of taken-branch flushes

## Operation
- Dependency terms:
  - dep(rd, wr) = wr && rd != 0 && (rd == RS1 || (IFID_Uses_RS2 && rd == RS2)).
  - Register x0 is never a hazard.
- Hazard classes, evaluated only in state RUN and only when IFID_Is_Branch = 1:
  - H2: dep(IDEX_Reg_RD, IDEX_RegWrite) && IDEX_MemRead. This is a load in EX and needs 2 stall cycles.
  - H1: dep(IDEX_Reg_RD, IDEX_RegWrite) && !IDEX_MemRead, or dep(EXMEM_Reg_RD, EXMEM_RegWrite) && EXMEM_MemRead. Each needs 1 stall cycle.
  - If H2 and H1 are both true, H2 wins.
- FSM states are RUN and HOLD. The state encoding is 1 bit.
  - RUN, H2 → stall this cycle, next state HOLD.
  - RUN, H1 → stall this cycle, stay in RUN. Next cycle the operand is forwardable and is re-evaluated.
  - RUN, no hazard → no stall.
  - HOLD → stall unconditionally, next state RUN. Dependency inputs are ignored in HOLD.
- Stall outputs:
  - stall = (RUN && (H1 || H2)) || HOLD.
  - PC_Write = IFID_Write = !stall.
  - IDEX_Bubble = stall.
- Flush: IFID_Flush = IFID_Is_Branch && Branch_Taken && !stall.
  - If stall and a taken branch occur together, the stall wins and Branch_Taken is ignored, because the operands are stale.
- Counters:
  - Stall_Cnt increments on every stall cycle; Flush_Cnt increments on every flush cycle.
  - Both saturate at 2^CNT_W − 1 with no wrap.
  - Clear_Counters forces both to 0 at the next edge and overrides an increment in the same cycle.
- Register-file write-back is write-through. A producer in MEM/WB is therefore never a hazard.

## Timing
- PC_Write, IFID_Write, IDEX_Bubble and IFID_Flush are combinational (Mealy) from the current state and inputs, with zero latency.
- Counters and the state register update on the rising edge of clk.
- Reset values while rst_n = 0 or after deassertion:
  - state = RUN, Stall_Cnt = 0, Flush_Cnt = 0.
  - With IFID_Is_Branch = 0: PC_Write = 1, IFID_Write = 1, IDEX_Bubble = 0, IFID_Flush = 0.
- Stall lengths:
  - An H2 branch stalls exactly 2 consecutive cycles.
  - An H1 branch stalls exactly 1 cycle.
  - Load-in-EX followed by an EX/MEM recheck must not produce a third cycle; HOLD returns to RUN, and by then the load is in MEM/WB.
- Reset asserted in HOLD returns the FSM to RUN immediately (asynchronous) and drops the stall.
- Back-to-back branches are evaluated independently once the FSM is back in RUN.

## Structure
- The shared package rv32_pkg holds:
  - REG_ADDR_W = 5
  - the hazard FSM state enum (RUN, HOLD)
  - constant X0 = 5'd0
- One combinational sub-module, branch_dep_check: inputs are the rd, write flag, rs1, rs2 and uses_rs2; output is the dependency bit. It is instantiated twice (EX producer, MEM producer).
- The FSM, stall/flush logic and counters live in the top level.

## Test plan
- Load-use branch: IDEX load rd = 5, branch RS1 = 5 → stall for 2 cycles (PC_Write = 0, IDEX_Bubble = 1), then PC_Write = 1; Stall_Cnt = 2.
- ALU-use branch: IDEX add rd = 7, RegWrite = 1, branch RS2 = 7, Uses_RS2 = 1 → 1 stall cycle; with Uses_RS2 = 0 → no stall.
- x0 and EX/MEM cases: IDEX rd = 0 writing → no stall. EXMEM load rd = 9, branch RS1 = 9 → 1 stall cycle.
- Taken flush: no hazard, Branch_Taken = 1 → IFID_Flush = 1 for 1 cycle and Flush_Cnt += 1. Same stimulus during an H2 stall → IFID_Flush = 0 until the stall ends.
- Counter saturation with CNT_W = 2: 5 stall cycles → Stall_Cnt holds at 3. Clear_Counters plus a stall in the same cycle → Stall_Cnt = 0.
- Reset mid-HOLD: rst_n low in the second H2 cycle → state RUN and PC_Write = 1 asynchronously, with counters at 0.
